bus_master_arbiter: RTL
=======================

// Module: bus_master_arbiter
// PURPOSE
//  Arbitrates the shared system bus among three masters: io, L2cache, uncache.
//  Sits between the master request/free lines and the bus/uart slave path.
//  Issues one registered, one-hot grant. Rotates priority round-robin.
//  Revokes a grant that is held too long and flags bus_error.
// PARAMETERS
//  TIMEOUT   1024  max cycles a grant is held without free; range 2..2^CNT_W-1
//  CNT_W     11    width of the hold/timeout counter
//  RR_EN     1     1 = round-robin priority; 0 = fixed priority io > L2cache > uncache
// PORTS
//  clk                input   1  system clock, rising edge
//  reset              input   1  asynchronous, active-low reset
//  io_bus_req         input   1  io master requests the bus (level)
//  L2cache_bus_req    input   1  L2cache master requests the bus (level)
//  uncache_bus_req    input   1  uncache master requests the bus (level)
//  io_bus_free        input   1  io master releases the bus (1-cycle pulse)
//  L2cache_bus_free   input   1  L2cache master releases the bus (1-cycle pulse)
//  uncache_bus_free   input   1  uncache master releases the bus (1-cycle pulse)
//  bus_io_grant       output  1  grant to io
//  bus_L2cache_grant  output  1  grant to L2cache
//  bus_uncache_grant  output  1  grant to uncache
//  bus_owner          output  2  0 none, 1 io, 2 L2cache, 3 uncache
//  bus_busy           output  1  high in GRANT and RELEASE states
//  bus_error          output  1  1-cycle pulse on timeout revoke
// BEHAVIOUR
//  Reset (reset==0, async):
//   - All grants 0, bus_owner=0, bus_busy=0, bus_error=0.
//   - State=IDLE, counter=0, last_owner=uncache, so io is highest priority first.
//  States: IDLE -> GRANT -> RELEASE -> IDLE.
//  IDLE:
//   - If any req=1 at edge k, pick winner; grant and bus_owner valid after edge k.
//   - Then go to GRANT with counter=0.
//   - No req: stay in IDLE with outputs 0.
//  Priority:
//   - RR_EN=1: search order starts at the master after last_owner (io->L2cache->uncache->io).
//   - last_owner updates when a grant is issued.
//   - RR_EN=0: fixed order io > L2cache > uncache.
//  GRANT:
//   - Grant held; counter increments every cycle.
//   - Owner's free=1 at edge m: all grants 0 after edge m; go to RELEASE.
//   - Free from a non-owner is ignored.
//   - Owner dropping req without free does not release the bus.
//   - counter==TIMEOUT-1 with no owner free: grants 0, bus_error=1 for one cycle; go to RELEASE.
//   - Owner free and timeout in the same cycle: free wins, bus_error stays 0.
//  RELEASE:
//   - One dead cycle, all grants 0, bus_busy=1. Then IDLE.
//   - Earliest new grant is after edge m+2. Requests during RELEASE are not lost;
//     they are level signals, sampled in IDLE.
//  Grant is never asserted to two masters at once. Outputs change only on clk or reset.
//  Reset mid-grant: grants drop immediately (async), state returns to IDLE.
//  Counter saturates; it cannot wrap while in GRANT.
// TESTING
//  1 Reset: hold reset=0 with all reqs=1 -> all grants 0, bus_owner=0, bus_error=0.
//  2 Single master: L2cache_bus_req=1 at edge 3 -> bus_L2cache_grant=1, bus_owner=2 after edge 3.
//    L2cache_bus_free pulse at edge 10 -> grant 0 after edge 10, bus_busy 0 after edge 11.
//  3 Round-robin (RR_EN=1): all three reqs held high, each owner frees 5 cycles after grant
//    -> grant order io, L2cache, uncache, io, with one dead cycle between grants.
//  4 Timeout (TIMEOUT=8): io granted and never frees -> grant drops after 8 GRANT cycles,
//    bus_error high exactly 1 cycle, next grant goes to L2cache if it is requesting.
//  5 Corner cases: uncache_bus_free pulses while io owns -> io grant unchanged.
//    Owner free on the timeout cycle -> bus_error stays 0.
//  6 Async reset: assert reset mid-GRANT between clock edges -> grant 0 with no clock edge;
//    after release with io_bus_req=1 -> io granted at the first edge.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// Shared system bus arbiter for the io, L2cache and uncache masters.
// Registered one-hot grant, round-robin or fixed priority, hold timeout with bus_error.
module bus_master_arbiter #(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 11,
   parameter bit          RR_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       io_bus_req,
   input  logic       L2cache_bus_req,
   input  logic       uncache_bus_req,
   input  logic       io_bus_free,
   input  logic       L2cache_bus_free,
   input  logic       uncache_bus_free,
   output logic       bus_io_grant,
   output logic       bus_L2cache_grant,
   output logic       bus_uncache_grant,
   output logic [1:0] bus_owner,
   output logic       bus_busy,
   output logic       bus_error
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   localparam logic [1:0]       OWN_NONE = 2'd0;
   localparam logic [1:0]       OWN_IO   = 2'd1;
   localparam logic [1:0]       OWN_L2   = 2'd2;
   localparam logic [1:0]       OWN_UNC  = 2'd3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       owner_q, owner_d;
   logic [1:0]       last_q, last_d;
   logic [2:0]       grant_q, grant_d;
   logic             busy_q, busy_d;
   logic             error_q, error_d;

   logic [2:0] req_c;
   logic [2:0] free_c;
   logic [1:0] pick_c;
   logic       owner_free_c;

   assign req_c        = {uncache_bus_req, L2cache_bus_req, io_bus_req};
   assign free_c       = {uncache_bus_free, L2cache_bus_free, io_bus_free};
   assign owner_free_c = |(grant_q & free_c);

   // Winner selection: search starts at the master after the last owner.
   always_comb begin
      pick_c = OWN_NONE;
      if (!RR_EN || last_q == OWN_UNC || last_q == OWN_NONE) begin
         if      (req_c[0]) pick_c = OWN_IO;
         else if (req_c[1]) pick_c = OWN_L2;
         else if (req_c[2]) pick_c = OWN_UNC;
      end else if (last_q == OWN_IO) begin
         if      (req_c[1]) pick_c = OWN_L2;
         else if (req_c[2]) pick_c = OWN_UNC;
         else if (req_c[0]) pick_c = OWN_IO;
      end else begin
         if      (req_c[2]) pick_c = OWN_UNC;
         else if (req_c[0]) pick_c = OWN_IO;
         else if (req_c[1]) pick_c = OWN_L2;
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      error_d = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = 3'b000;
            owner_d = OWN_NONE;
            busy_d  = 1'b0;
            cnt_d   = '0;
            if (pick_c != OWN_NONE) begin
               state_d = GRANT;
               owner_d = pick_c;
               last_d  = pick_c;
               grant_d = {pick_c == OWN_UNC, pick_c == OWN_L2, pick_c == OWN_IO};
               busy_d  = 1'b1;
            end
         end
         GRANT: begin
            busy_d = 1'b1;
            if (owner_free_c || cnt_q == CNT_LAST) begin
               state_d = RELEASE;
               grant_d = 3'b000;
               owner_d = OWN_NONE;
               error_d = !owner_free_c;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
            grant_d = 3'b000;
            owner_d = OWN_NONE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            grant_d = 3'b000;
            owner_d = OWN_NONE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= OWN_NONE;
         last_q  <= OWN_UNC;
         grant_q <= 3'b000;
         busy_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         error_q <= error_d;
      end
   end

   assign bus_io_grant      = grant_q[0];
   assign bus_L2cache_grant = grant_q[1];
   assign bus_uncache_grant = grant_q[2];
   assign bus_owner         = owner_q;
   assign bus_busy          = busy_q;
   assign bus_error         = error_q;

endmodule
